// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_bus_responder slice: FSM state
// encoding, full-word byte mask, out-of-window read pattern, wait counter width.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0]  BE_WORD  = 4'b1111;
    localparam logic [31:0] BAD_READ = 32'hDEAD_BEEF;
    localparam int          WAIT_W   = 4;

endpackage

// File: rtl/mem_bus_responder_if.sv
// Avalon-style memory bus between a CPU-side master and the memory responder.
// Optional feature macro: MEM_ERR_EN adds the err (out-of-window) signal.
interface mem_bus_responder_if;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
`ifdef MEM_ERR_EN
    logic        err;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest, err
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest, err
    );
`else
    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest
    );
`endif

endinterface

// File: rtl/mem_bytelane_ram.sv
// Four byte-wide memory arrays with per-lane write enables and a shared
// registered read port. The read register only loads when asked, so it holds
// the last response between accesses; a synchronous clear forces it to zero.
module mem_bytelane_ram #(
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [3:0]        i_we,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic              i_rd_en,
    input  logic              i_rd_clr,
    output logic [31:0]       o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    for (genvar n = 0; n < 4; n++) begin : g_lane
        logic [7:0]  r_mem [DEPTH];
        logic [7:0]  r_q;

        // Byte-lane write, committed only when this lane is enabled
        always_ff @(posedge clk) begin
            if (i_we[n]) begin
                r_mem[i_waddr] <= i_wdata[8*n +: 8];
            end
        end

        // Registered read: clear wins, otherwise load on request, else hold
        always_ff @(posedge clk) begin
            if (i_rd_clr) begin
                r_q <= 8'h00;
            end else if (i_rd_en) begin
                r_q <= r_mem[i_raddr];
            end
        end

        assign o_rdata[8*n +: 8] = r_q;
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for an Avalon-style CPU bus backing one contiguous
// window of 2**WORDS_LOG2 words starting at BASE_ADDR. Each access walks
// IDLE -> (WAIT x WAIT_CYCLES) -> RESP -> IDLE; the transfer is accepted at
// the edge that ends RESP. Optional feature macro: MEM_ERR_EN (err port,
// 32'hDEAD_BEEF returned for out-of-window reads).
module mem_bus_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
    parameter int          WORDS_LOG2  = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input logic                clk,
    input logic                reset,
    mem_bus_responder_if.slave bus
);

`ifdef MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Counter reload: WAIT lasts WAIT_CYCLES cycles, counting down to zero.
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    state_t                  r_state;
    logic [WAIT_W-1:0]       r_wait_cnt;
    logic [WORDS_LOG2-1:0]   r_index;
    logic                    r_is_write;
    logic                    r_oow;
    logic                    r_bad_rd;

    logic                    w_req;
    logic [29:0]             w_word_off;
    logic [WORDS_LOG2-1:0]   w_live_index;
    logic                    w_live_oow;
    logic [WORDS_LOG2-1:0]   w_cur_index;
    logic                    w_cur_write;
    logic                    w_cur_oow;
    logic                    w_enter_resp;
    logic [3:0]              w_we;
    logic                    w_rd_en;
    logic                    w_rd_clr;
    logic [31:0]             w_ram_q;

    assign w_req = bus.read | bus.write;

    // Window decode on word offsets; BASE_ADDR is word-aligned, so dropping
    // the byte bits before subtracting gives the same index as (addr-base)>>2.
    assign w_word_off   = bus.address[31:2] - BASE_ADDR[31:2];
    assign w_live_index = w_word_off[WORDS_LOG2-1:0];
    assign w_live_oow   = (bus.address < BASE_ADDR) ||
                          ((w_word_off >> WORDS_LOG2) != 30'd0);

    // In IDLE the access is described by the live bus; afterwards by the latch.
    assign w_cur_index = (r_state == IDLE) ? w_live_index : r_index;
    assign w_cur_write = (r_state == IDLE) ? bus.write    : r_is_write;
    assign w_cur_oow   = (r_state == IDLE) ? w_live_oow   : r_oow;

    assign w_enter_resp = w_req &&
                          (((r_state == IDLE) && (WAIT_CYCLES == 0)) ||
                           ((r_state == WAIT) && (r_wait_cnt == '0)));

    // Read data is captured as RESP begins; writes and out-of-window accesses
    // zero the read register instead (DEAD_BEEF is muxed in separately).
    assign w_rd_en  = w_enter_resp && !w_cur_write && !w_cur_oow;
    assign w_rd_clr = reset || (w_enter_resp && (w_cur_write || w_cur_oow));

    // Commit at the edge ending RESP; a reset in that cycle drops the write.
    assign w_we = (r_state == RESP && r_is_write && bus.write && !r_oow && !reset)
                  ? bus.byteenable : 4'b0000;

    mem_bytelane_ram #(
        .ADDR_W    (WORDS_LOG2),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk      (clk),
        .i_waddr  (r_index),
        .i_we     (w_we),
        .i_wdata  (bus.writedata),
        .i_raddr  (w_cur_index),
        .i_rd_en  (w_rd_en),
        .i_rd_clr (w_rd_clr),
        .o_rdata  (w_ram_q)
    );

    // Access sequencing: accept a request, stall WAIT_CYCLES, respond once
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (WAIT_CYCLES == 0) begin
                            r_state <= RESP;
                        end else begin
                            r_state    <= WAIT;
                            r_wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!w_req) begin
                        r_state    <= IDLE;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Latch the access description when a request is seen in IDLE
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_req) begin
            r_index    <= w_live_index;
            r_is_write <= bus.write;
            r_oow      <= w_live_oow;
        end
    end

    // Remember whether the current response is the out-of-window pattern
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bad_rd <= 1'b0;
        end else if (w_enter_resp) begin
            r_bad_rd <= ERR_EN && w_cur_oow && !w_cur_write;
        end
    end

    assign bus.waitrequest = w_req && (r_state != RESP);
    assign bus.readdata    = r_bad_rd ? BAD_READ : w_ram_q;

`ifdef MEM_ERR_EN
    logic r_err;

    // err is high for exactly the RESP cycle of an out-of-window access
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_enter_resp && w_cur_oow;
        end
    end

    assign bus.err = r_err;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: two instances (WAIT_CYCLES=1 and 0) share
// clock and reset. A transaction-level memory model predicts waitrequest,
// readdata and err every cycle; directed accesses pin literal values.
module tb_mem_bus_responder;

    localparam logic [31:0] BASE = 32'hBFC0_0000;
    localparam int          NW   = 1024;
`ifdef MEM_ERR_EN
    localparam logic [31:0] OOW_READ = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] OOW_READ = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_responder_if bus0();
    mem_bus_responder_if bus1();

    logic [31:0] d_addr [2];
    logic        d_rd   [2];
    logic        d_wr   [2];
    logic [3:0]  d_be   [2];
    logic [31:0] d_wd   [2];
    logic        o_wait [2];
    logic [31:0] o_rdat [2];

    assign bus0.address    = d_addr[0];
    assign bus0.read       = d_rd[0];
    assign bus0.write      = d_wr[0];
    assign bus0.byteenable = d_be[0];
    assign bus0.writedata  = d_wd[0];
    assign bus1.address    = d_addr[1];
    assign bus1.read       = d_rd[1];
    assign bus1.write      = d_wr[1];
    assign bus1.byteenable = d_be[1];
    assign bus1.writedata  = d_wd[1];
    assign o_wait[0] = bus0.waitrequest;
    assign o_wait[1] = bus1.waitrequest;
    assign o_rdat[0] = bus0.readdata;
    assign o_rdat[1] = bus1.readdata;
`ifdef MEM_ERR_EN
    logic o_err [2];
    assign o_err[0] = bus0.err;
    assign o_err[1] = bus1.err;
`endif

    mem_bus_responder #(.BASE_ADDR(BASE), .WORDS_LOG2(10), .WAIT_CYCLES(1), .INIT_FILE(""))
        dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    mem_bus_responder #(.BASE_ADDR(BASE), .WORDS_LOG2(10), .WAIT_CYCLES(0), .INIT_FILE(""))
        dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_mem [2][NW];
    int          m_age [2];     // cycles the current request has been held
    logic        s_wait [2];
    logic [31:0] s_rdat [2];

    function automatic int wc(input int g);
        return (g == 0) ? 1 : 0;
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'd4096);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model (called at negedge)
    task automatic compare_all();
        for (int g = 0; g < 2; g++) begin
            bit          req, resp;
            logic [31:0] exp;
            req  = d_rd[g] | d_wr[g];
            resp = req && (m_age[g] == wc(g) + 1);
            check($sformatf("waitrequest[%0d]", g), {31'b0, o_wait[g]}, {31'b0, req && !resp});
            if (resp) begin
                if (d_wr[g])                exp = 32'h0;
                else if (!in_win(d_addr[g])) exp = OOW_READ;
                else                        exp = m_mem[g][widx(d_addr[g])];
                check($sformatf("readdata[%0d]", g), o_rdat[g], exp);
            end
`ifdef MEM_ERR_EN
            check($sformatf("err[%0d]", g), {31'b0, o_err[g]},
                  {31'b0, resp && !in_win(d_addr[g])});
`endif
            s_wait[g] = o_wait[g];
            s_rdat[g] = o_rdat[g];
        end
    endtask

    // Model advance at the rising edge, using the inputs of the ending cycle
    task automatic model_step();
        for (int g = 0; g < 2; g++) begin
            bit req;
            req = d_rd[g] | d_wr[g];
            if (reset) begin
                m_age[g] = 0;
            end else if (req && m_age[g] == wc(g) + 1) begin
                if (d_wr[g] && in_win(d_addr[g])) begin
                    for (int n = 0; n < 4; n++)
                        if (d_be[g][n]) m_mem[g][widx(d_addr[g])][8*n +: 8] = d_wd[g][8*n +: 8];
                end
                m_age[g] = 0;
            end else if (req) begin
                m_age[g] = m_age[g] + 1;
            end else begin
                m_age[g] = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input int g, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        d_rd[g] = rd; d_wr[g] = wr; d_addr[g] = a; d_be[g] = be; d_wd[g] = wd;
    endtask

    task automatic idle(input int g);
        d_rd[g] = 1'b0; d_wr[g] = 1'b0;
    endtask

    // Hold a request until accepted; leaves it asserted for back-to-back use
    task automatic access(input int g, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          output logic [31:0] rdata, output int stalls);
        bit done = 0;
        drive(g, rd, wr, a, be, wd);
        stalls = 0;
        rdata  = 32'h0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (!s_wait[g]) begin
                done  = 1;
                rdata = s_rdat[g];
            end else begin
                stalls++;
            end
        end
        check($sformatf("accept_within_bound[%0d]", g), {31'b0, done}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd, a;
        int          st, r;
        logic [31:0] oow_list [4];
        oow_list[0] = 32'h0000_0000; oow_list[1] = BASE - 32'd4;
        oow_list[2] = BASE + 32'd4096; oow_list[3] = 32'hFFFF_FFFC;

        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            drive(g, 1'b0, 1'b0, BASE, 4'h0, 32'h0);
            m_age[g] = 0;
            for (int w = 0; w < NW; w++) m_mem[g][w] = 32'h0;
        end
        tick(); tick();
        reset = 1'b0;
        check("reset_readdata0", o_rdat[0], 32'h0);
        check("reset_readdata1", o_rdat[1], 32'h0);
        check("reset_wait0", {31'b0, o_wait[0]}, 32'd0);

        // Preload the words that the random phase reads
        for (int g = 0; g < 2; g++) begin
            for (int w = 0; w < 16; w++)
                access(g, 1'b0, 1'b1, BASE + 32'(4*w), 4'hF, $urandom, rd, st);
            idle(g); tick();
        end

        // Full-word write and readback, WAIT_CYCLES=1: two stall cycles each
        access(0, 1'b0, 1'b1, BASE, 4'hF, 32'h1122_3344, rd, st);
        check("t1_write_stalls", st, 2);
        idle(0); tick();
        access(0, 1'b1, 1'b0, BASE, 4'h0, 32'h0, rd, st);
        check("t1_read_stalls", st, 2);
        check("t1_readback", rd, 32'h1122_3344);
        idle(0); tick();

        // Single-lane write over all-ones
        access(0, 1'b0, 1'b1, BASE + 32'd4, 4'hF, 32'hFFFF_FFFF, rd, st);
        access(0, 1'b0, 1'b1, BASE + 32'd4, 4'b0100, 32'h00AB_0000, rd, st);
        access(0, 1'b0, 1'b1, BASE + 32'd4, 4'b0000, 32'h1234_5678, rd, st);
        access(0, 1'b1, 1'b0, BASE + 32'd4, 4'h0, 32'h0, rd, st);
        check("t2_lane_merge", rd, 32'hFFAB_FFFF);
        idle(0); tick();

        // Out-of-window accesses: fixed read value, no memory change
        access(0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'h0, rd, st);
        check("t4_oow_read", rd, OOW_READ);
        check("t4_oow_stalls", st, 2);
        access(0, 1'b0, 1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_CAFE, rd, st);
        access(0, 1'b0, 1'b1, BASE + 32'd4096, 4'hF, 32'hCAFE_CAFE, rd, st);
        access(0, 1'b1, 1'b0, BASE - 32'd4, 4'h0, 32'h0, rd, st);
        check("t4_below_base", rd, OOW_READ);
        access(0, 1'b1, 1'b0, BASE, 4'h0, 32'h0, rd, st);
        check("t4_word0_unchanged", rd, 32'h1122_3344);
        idle(0); tick();

        // Reset during WAIT drops the in-flight write
        access(0, 1'b0, 1'b1, BASE + 32'd8, 4'hF, 32'h0BAD_F00D, rd, st);
        idle(0); tick();
        drive(0, 1'b0, 1'b1, BASE + 32'd8, 4'hF, 32'h1234_5678);
        tick();
        reset = 1'b1;
        idle(0);
        tick();
        reset = 1'b0;
        check("t5_wait_low", {31'b0, o_wait[0]}, 32'd0);
        check("t5_readdata_reset", o_rdat[0], 32'h0);
        access(0, 1'b1, 1'b0, BASE + 32'd8, 4'h0, 32'h0, rd, st);
        check("t5_idle_latency", st, 2);
        check("t5_word_kept", rd, 32'h0BAD_F00D);
        idle(0); tick();

        // read and write together: write wins, readdata zero
        access(0, 1'b1, 1'b1, BASE + 32'd8, 4'hF, 32'h5A5A_5A5A, rd, st);
        check("t6_both_readdata", rd, 32'h0);
        access(0, 1'b1, 1'b0, BASE + 32'd8, 4'h0, 32'h0, rd, st);
        check("t6_readback", rd, 32'h5A5A_5A5A);
        idle(0); tick();

        // WAIT_CYCLES=0: back-to-back accesses, each accepted on its 2nd cycle
        for (int i = 0; i < 4; i++) begin
            access(1, 1'b0, 1'b1, BASE + 32'(16 + 4*i), 4'hF, 32'hA000_0000 + 32'(i), rd, st);
            check("t3_write_stalls", st, 1);
        end
        for (int i = 0; i < 4; i++) begin
            access(1, 1'b1, 1'b0, BASE + 32'(16 + 4*i), 4'h0, 32'h0, rd, st);
            check("t3_read_stalls", st, 1);
            check("t3_read_value", rd, 32'hA000_0000 + 32'(i));
        end
        idle(1); tick();

        // Randomized traffic, checked every cycle by the model
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 200; k++) begin
                logic rq, wq;
                r  = int'($urandom_range(0, 99));
                a  = (r % 10 == 0) ? oow_list[$urandom_range(0, 3)]
                                   : BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
                rq = (r < 50) || (r >= 90);
                wq = (r >= 50);
                if (g == 0 && r < 8) begin
                    drive(g, rq, wq, a, 4'($urandom), $urandom);
                    tick();
                    idle(g);
                    tick();
                end else begin
                    access(g, rq, wq, a, 4'($urandom), $urandom, rd, st);
                    if ($urandom_range(0, 1) == 1) begin
                        idle(g);
                        repeat ($urandom_range(1, 3)) tick();
                    end
                end
            end
            idle(g); tick();
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
